note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//   Step sequencer that feeds the audio voice path: it plays a 16-step note pattern at a programmable tempo.
//   Per step it outputs a 4-bit note index for scale_rom and a gate that the top level ANDs with the voice output.
//   It also produces the ~1 MHz enable pulse consumed by the voice.
//   Sits between ui_in/uio_in configuration pins and the scale_rom/voice pair in the top level.
// PARAMETERS
//   CLK_DIV    26  clk cycles per tick (25 MHz clk -> ~0.96 MHz tick); legal range 2..255
//   STEPS      16  pattern length; must be a power of two, max 16
//   GAP_TICKS  64  ticks of gate-low at the end of every step (articulation gap)
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   synchronous active-low reset
//   start        in   1   level-insensitive pulse; begins playback from step 0
//   stop         in   1   pulse; aborts playback, returns to IDLE
//   tempo        in   16  ticks per step; values < GAP_TICKS+1 are clamped to GAP_TICKS+1
//   wr_en        in   1   pattern write strobe
//   wr_addr      in   4   pattern step address
//   wr_data      in   5   {rest, note[3:0]}; rest=1 keeps gate low for the step
//   tick         out  1   one-clk pulse every CLK_DIV clks (voice enable); runs in all states
//   note_out     out  4   note index of current step (registered)
//   gate         out  1   high while the current non-rest step sounds
//   step_idx     out  4   current step number
//   step_strobe  out  1   one-clk pulse on the clk a new step is entered
//   busy         out  1   high in PLAY or GAP
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, tick divider=0, pattern RAM cleared to 5'b0 (note 0, no rest).
//   Tick divider: counts 0..CLK_DIV-1; tick=1 on the clk the count wraps to 0; not gated by FSM.
//   FSM states: IDLE, PLAY, GAP.
//     IDLE: on start -> PLAY, step_idx=0, step ticks=0, step_strobe=1 next clk, note_out=pattern[0].
//     PLAY: count ticks; gate=~rest. When count == tempo_eff-GAP_TICKS -> GAP, gate=0.
//     GAP: when count == tempo_eff-1 (on a tick) -> advance step (see wrap rules), count=0, re-enter PLAY.
//   Latency: start sampled at clk N -> busy, step_strobe, note_out valid at N+1; gate high at N+1 unless rest.
//   tempo is sampled at step entry (tempo_eff); changes mid-step take effect at the next step.
//   Wrap-around: after step STEPS-1, behaviour per SEQ_LOOP_EN (below).
//   stop has priority over start and over step advance: busy, gate, step_strobe=0 on next clk; step_idx held.
//   start while busy: restart at step 0 (same as from IDLE), count cleared.
//   Pattern write: takes effect next clk. A write to the currently playing step does NOT change note_out
//     until that step is re-entered. Writes are accepted in every state.
//   Write to the step being entered on the same clk: the new data is used (write-first bypass).
//   Arithmetic: step tick counter is 16 bits wide and never wraps, because tempo_eff is the terminal count.
// CONFIGURATION
//   SEQ_LOOP_EN defined: after step STEPS-1 the sequencer wraps to step 0 and keeps playing until stop.
//   SEQ_LOOP_EN undefined: after GAP of step STEPS-1 -> IDLE (busy=0, step_idx=0), with no step_strobe.
// STRUCTURE
//   seq_pkg: state encoding (IDLE=2'd0, PLAY=2'd1, GAP=2'd2), STEP_W=4, NOTE_W=4, ENTRY_W=5 constants.
//   Sub-module seq_tick_div (parameter CLK_DIV, ports clk, rst_n, tick) holds the divider.
//   Pattern storage is a 16x5 flop array in note_sequencer, not a macro.
// TESTING
//   Reset, then 100 clks idle -> tick every 26 clks, busy=0, gate=0, note_out=0.
//   Write steps 0..3 = notes 1,2,3,4; tempo=100; start -> step_strobe every 2600 clks; note_out
//     follows 1,2,3,4; gate high 36 ticks, low 64 ticks per step.
//   Step 2 written with rest=1 -> gate stays 0 throughout step 2; note_out still updates.
//   tempo=10 (below clamp) -> step length 65 ticks.
//   stop mid-PLAY on step 5 -> busy=0, gate=0 next clk, step_idx=5.
//   Then start -> step_idx=0.
//   Run past step 15: with SEQ_LOOP_EN, step_idx 15->0 with step_strobe;
//     without it, busy drops and there is no strobe.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the note sequencer.
// Provides the FSM state encoding, field widths, pattern entry layout and tempo clamp.
package seq_pkg;

    localparam int STEP_W  = 4;
    localparam int NOTE_W  = 4;
    localparam int ENTRY_W = 5;
    localparam int TEMPO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              rest;
        logic [NOTE_W-1:0] note;
    } entry_t;

    // A step must leave at least one sounding tick ahead of the gap.
    function automatic logic [TEMPO_W-1:0] clamp_tempo(
        input logic [TEMPO_W-1:0] t,
        input logic [TEMPO_W-1:0] min_t
    );
        return (t < min_t) ? min_t : t;
    endfunction

endpackage

// File: rtl/seq_tick_div.sv
// Free-running clock divider producing the ~1 MHz voice enable tick.
// Ports: clk, rst_n (sync, active-low) in; tick out (one clk every CLK_DIV clks).
module seq_tick_div #(
    parameter int CLK_DIV = 26
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// 16-step note sequencer: plays a stored pattern at a programmable tempo, emits note/gate/tick.
// Ports: clk, rst_n, start, stop, tempo[15:0], wr_en, wr_addr[3:0], wr_data[4:0] in;
//        tick, note_out[3:0], gate, step_idx[3:0], step_strobe, busy out.
// Build option: define SEQ_LOOP_EN to wrap from the last step back to step 0 instead of stopping.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int CLK_DIV   = 26,
    parameter int STEPS     = 16,
    parameter int GAP_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic               wr_en,
    input  logic [STEP_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic               tick,
    output logic [NOTE_W-1:0]  note_out,
    output logic               gate,
    output logic [STEP_W-1:0]  step_idx,
    output logic               step_strobe,
    output logic               busy
);

    localparam int DEPTH = 2 ** STEP_W;
    localparam logic [TEMPO_W-1:0] MIN_TEMPO = TEMPO_W'(GAP_TICKS + 1);
    localparam logic [TEMPO_W-1:0] GAP_LEN   = TEMPO_W'(GAP_TICKS);
    localparam logic [STEP_W-1:0]  LAST      = STEP_W'(STEPS - 1);

    entry_t              pattern [DEPTH];
    state_t              state;
    logic [TEMPO_W-1:0]  count;
    logic [TEMPO_W-1:0]  tempo_eff;
    logic [STEP_W-1:0]   enter_step;
    entry_t              enter_ent;
    logic                step_done;
    logic                seq_end;

    seq_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef SEQ_LOOP_EN
    assign seq_end = 1'b0;
`else
    assign seq_end = (step_idx == LAST);
`endif

    assign step_done = (state == GAP) && tick
                     && (count == tempo_eff - TEMPO_W'(1));

    // Entry data with write-first bypass so a same-clk write is seen.
    always_comb begin
        enter_step = start ? '0 : ((step_idx + STEP_W'(1)) & LAST);
        enter_ent  = pattern[enter_step];
        if (wr_en && (wr_addr == enter_step))
            enter_ent = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                pattern[i] <= '0;
        end else if (wr_en) begin
            pattern[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            tempo_eff   <= '0;
            note_out    <= '0;
            gate        <= 1'b0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                gate  <= 1'b0;
            end else if (start || (step_done && !seq_end)) begin
                state       <= PLAY;
                step_idx    <= enter_step;
                count       <= '0;
                tempo_eff   <= clamp_tempo(tempo, MIN_TEMPO);
                note_out    <= enter_ent.note;
                gate        <= ~enter_ent.rest;
                step_strobe <= 1'b1;
                busy        <= 1'b1;
            end else if (step_done) begin
                state    <= IDLE;
                busy     <= 1'b0;
                gate     <= 1'b0;
                step_idx <= '0;
                count    <= '0;
            end else if (tick) begin
                unique case (state)
                    PLAY: begin
                        count <= count + TEMPO_W'(1);
                        if (count + TEMPO_W'(1) == tempo_eff - GAP_LEN) begin
                            state <= GAP;
                            gate  <= 1'b0;
                        end
                    end
                    GAP:     count <= count + TEMPO_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule
